// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier with start/busy/ready handshake.
// Shift-add significand product, flush-to-zero on inputs and results, round-to-nearest-even.
module fp_mul_seq #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  output logic [31:0] product,
  output logic [3:0]  flags,
  output logic        busy,
  output logic        ready
);

  localparam int unsigned MulCycles = 24 / BITS_PER_CYCLE;
  localparam logic [4:0]  MulCyclesW = 5'(MulCycles);
  localparam logic [31:0] QNan = 32'h7fc0_0000;

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4)) begin : gen_bad_bpc
    $error("fp_mul_seq: BITS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [2:0] {StIdle, StUnpack, StMul, StNorm, StRound, StDone} state_e;

  state_e state_q, state_d;

  logic [31:0]       a_q, b_q;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [23:0]       ma_q, mb_q;
  logic [47:0]       acc_q;
  logic [4:0]        cnt_q;
  logic [23:0]       mant_q;
  logic              guard_q, round_q, sticky_q;
  logic              spec_q;
  logic [31:0]       spec_prod_q;
  logic [3:0]        spec_flags_q;
  logic [31:0]       product_q;
  logic [3:0]        flags_q;

  // Operand classification (denormals already look like zero since only ea==0 is tested)
  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic              sign_n;
  logic signed [9:0] exp_sum;

  always_comb begin
    ea      = a_q[30:23];
    eb      = b_q[30:23];
    fa      = a_q[22:0];
    fb      = b_q[22:0];
    a_zero  = (ea == 8'h00);
    b_zero  = (eb == 8'h00);
    a_inf   = (ea == 8'hff) && (fa == 23'h0);
    b_inf   = (eb == 8'hff) && (fb == 23'h0);
    a_nan   = (ea == 8'hff) && (fa != 23'h0);
    b_nan   = (eb == 8'hff) && (fb != 23'h0);
    a_snan  = a_nan && !fa[22];
    b_snan  = b_nan && !fb[22];
    sign_n  = a_q[31] ^ b_q[31];
    exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
  end

  logic        spec_hit;
  logic [31:0] spec_prod;
  logic [3:0]  spec_flags;

  always_comb begin
    spec_hit   = 1'b1;
    spec_prod  = 32'h0;
    spec_flags = 4'h0;
    if (a_nan || b_nan) begin
      spec_prod  = QNan;
      spec_flags = {a_snan || b_snan, 3'b000};
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      spec_prod  = QNan;
      spec_flags = 4'b1000;
    end else if (a_inf || b_inf) begin
      spec_prod = {sign_n, 31'h7f80_0000};
    end else if (a_zero || b_zero) begin
      spec_prod = {sign_n, 31'h0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // MSB-first shift-add: retire BITS_PER_CYCLE multiplier bits per cycle
  logic [47:0] acc_step;
  logic [23:0] mb_step;

  always_comb begin
    acc_step = acc_q;
    mb_step  = mb_q;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      acc_step = {acc_step[46:0], 1'b0} + (mb_step[23] ? {24'h0, ma_q} : 48'h0);
      mb_step  = {mb_step[22:0], 1'b0};
    end
  end

  logic [23:0]       mant_n;
  logic              guard_n, round_n, sticky_n;
  logic signed [9:0] exp_n;

  always_comb begin
    if (acc_q[47]) begin
      mant_n   = acc_q[47:24];
      guard_n  = acc_q[23];
      round_n  = acc_q[22];
      sticky_n = |acc_q[21:0];
      exp_n    = exp_q + 10'sd1;
    end else begin
      mant_n   = acc_q[46:23];
      guard_n  = acc_q[22];
      round_n  = acc_q[21];
      sticky_n = |acc_q[20:0];
      exp_n    = exp_q;
    end
  end

  logic              round_up;
  logic [24:0]       mant_sum;
  logic [22:0]       frac_r;
  logic signed [9:0] exp_r;
  logic              inexact_r;
  logic [31:0]       res_prod;
  logic [3:0]        res_flags;

  always_comb begin
    round_up  = guard_q & (round_q | sticky_q | mant_q[0]);
    mant_sum  = {1'b0, mant_q} + {24'h0, round_up};
    inexact_r = guard_q | round_q | sticky_q;
    if (mant_sum[24]) begin
      frac_r = mant_sum[23:1];
      exp_r  = exp_q + 10'sd1;
    end else begin
      frac_r = mant_sum[22:0];
      exp_r  = exp_q;
    end
    if (spec_q) begin
      res_prod  = spec_prod_q;
      res_flags = spec_flags_q;
    end else if (exp_r >= 10'sd255) begin
      res_prod  = {sign_q, 31'h7f80_0000};
      res_flags = 4'b0101;
    end else if (exp_r <= 10'sd0) begin
      res_prod  = {sign_q, 31'h0};
      res_flags = 4'b0011;
    end else begin
      res_prod  = {sign_q, exp_r[7:0], frac_r};
      res_flags = {3'b000, inexact_r};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StUnpack;
      StUnpack: state_d = StMul;
      StMul:    if (cnt_q == 5'd1) state_d = StNorm;
      StNorm:   state_d = StRound;
      StRound:  state_d = StDone;
      StDone:   state_d = start ? StUnpack : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      a_q          <= '0;
      b_q          <= '0;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      ma_q         <= '0;
      mb_q         <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      mant_q       <= '0;
      guard_q      <= 1'b0;
      round_q      <= 1'b0;
      sticky_q     <= 1'b0;
      spec_q       <= 1'b0;
      spec_prod_q  <= '0;
      spec_flags_q <= '0;
      product_q    <= '0;
      flags_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
          end
        end
        StUnpack: begin
          sign_q       <= sign_n;
          exp_q        <= exp_sum;
          ma_q         <= {1'b1, fa};
          mb_q         <= {1'b1, fb};
          acc_q        <= '0;
          cnt_q        <= MulCyclesW;
          spec_q       <= spec_hit;
          spec_prod_q  <= spec_prod;
          spec_flags_q <= spec_flags;
        end
        StMul: begin
          acc_q <= acc_step;
          mb_q  <= mb_step;
          cnt_q <= cnt_q - 5'd1;
        end
        StNorm: begin
          mant_q   <= mant_n;
          guard_q  <= guard_n;
          round_q  <= round_n;
          sticky_q <= sticky_n;
          exp_q    <= exp_n;
        end
        StRound: begin
          product_q <= res_prod;
          flags_q   <= res_flags;
        end
        default: ;
      endcase
    end
  end

  assign product = product_q;
  assign flags   = flags_q;
  assign busy    = (state_q == StUnpack) || (state_q == StMul) ||
                   (state_q == StNorm) || (state_q == StRound);
  assign ready   = (state_q == StDone);

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: three instances (1, 2, 4 bits per cycle) checked every cycle against an
// arithmetic reference model, plus directed vectors with hand-computed results and latencies.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [2:0]  start_v = '0;
  logic [31:0] prod_w [3];
  logic [3:0]  flags_w [3];
  logic [2:0]  busy_w, ready_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int unsigned Bpc = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    fp_mul_seq #(.BITS_PER_CYCLE(Bpc)) u_dut (
      .clk     (clk),
      .clrn    (clrn),
      .a       (a_in),
      .b       (b_in),
      .start   (start_v[g]),
      .product (prod_w[g]),
      .flags   (flags_w[g]),
      .busy    (busy_w[g]),
      .ready   (ready_w[g])
    );
  end

  function automatic int lat(input int k);
    return (k == 0) ? 27 : (k == 1) ? 15 : 9;
  endfunction

  // Reference: exact integer product, then round by comparing the remainder with one half
  function automatic logic [35:0] model_mul(input logic [31:0] x, input logic [31:0] y);
    logic s, xz, yz, xi, yi, xn, yn, xs, ys, inx;
    int ex, ey, e, sh;
    longint unsigned mx, my, p, q, rem, half;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    xs = xn && !x[22];
    ys = yn && !y[22];
    if (xn || yn) return {xs || ys, 3'b000, 32'h7fc0_0000};
    if ((xi && yz) || (xz && yi)) return {4'b1000, 32'h7fc0_0000};
    if (xi || yi) return {4'b0000, s, 31'h7f80_0000};
    if (xz || yz) return {4'b0000, s, 31'h0};
    mx = 64'(x[22:0]) + (64'd1 << 23);
    my = 64'(y[22:0]) + (64'd1 << 23);
    p  = mx * my;
    e  = ex + ey - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e++;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    inx  = (rem != 0);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {4'b0101, s, 31'h7f80_0000};
    if (e <= 0) return {4'b0011, s, 31'h0};
    return {3'b000, inx, s, 8'(e), q[22:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Timeline model: pending result and cycles remaining per instance
  int          rem_m [3];
  logic [35:0] pend_m [3];
  logic [35:0] out_m [3];
  logic [2:0]  rdy_m;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int k = 0; k < 3; k++) begin
        rem_m[k]  <= 0;
        out_m[k]  <= '0;
        pend_m[k] <= '0;
        rdy_m[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (rem_m[k] == 0) begin
          rdy_m[k] <= 1'b0;
          if (start_v[k]) begin
            pend_m[k] <= model_mul(a_in, b_in);
            rem_m[k]  <= lat(k);
          end
        end else begin
          rem_m[k] <= rem_m[k] - 1;
          rdy_m[k] <= (rem_m[k] == 1);
          if (rem_m[k] == 1) out_m[k] <= pend_m[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("cyc_busy[%0d]", k), 64'(busy_w[k]), 64'(rem_m[k] != 0));
      chk($sformatf("cyc_ready[%0d]", k), 64'(ready_w[k]), 64'(rdy_m[k]));
      chk($sformatf("cyc_product[%0d]", k), 64'(prod_w[k]), 64'(out_m[k][31:0]));
      chk($sformatf("cyc_flags[%0d]", k), 64'(flags_w[k]), 64'(out_m[k][35:32]));
    end
  end

  // Issue one operation on instance k, wait for ready, check latency and literal result
  task automatic run_op(input int k, input bit now, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ep, input logic [3:0] ef, input string name);
    int n;
    if (!now) begin
      @(posedge clk);
      #1;
    end
    a_in       = x;
    b_in       = y;
    start_v[k] = 1'b1;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    n = 0;
    while (!ready_w[k] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(lat(k)));
    chk({name, "_product"}, 64'(prod_w[k]), 64'(ep));
    chk({name, "_flags"}, 64'(flags_w[k]), 64'(ef));
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] p;
    logic [3:0]  f;
    string       name;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int n;
    int pulses;
    vecs.push_back('{32'h4000_0000, 32'h3f00_0000, 32'h3f80_0000, 4'h0, "basic"});
    vecs.push_back('{32'h4040_0000, 32'hbfc0_0000, 32'hc090_0000, 4'h0, "sign_norm"});
    vecs.push_back('{32'h3f80_0001, 32'h3f80_0001, 32'h3f80_0002, 4'h1, "round_sticky"});
    vecs.push_back('{32'h3f80_0001, 32'h3f80_0000, 32'h3f80_0001, 4'h0, "exact"});
    vecs.push_back('{32'h3fc0_0000, 32'h3f80_0001, 32'h3fc0_0002, 4'h1, "tie_odd"});
    vecs.push_back('{32'h3fc0_0000, 32'h3f80_0003, 32'h3fc0_0004, 4'h1, "tie_even"});
    vecs.push_back('{32'h7f80_0000, 32'h0000_0000, 32'h7fc0_0000, 4'h8, "inf_x_zero"});
    vecs.push_back('{32'hff80_0000, 32'h4000_0000, 32'hff80_0000, 4'h0, "neg_inf"});
    vecs.push_back('{32'h0040_0000, 32'h4000_0000, 32'h0000_0000, 4'h0, "denorm_ftz"});
    vecs.push_back('{32'h7f80_0001, 32'h3f80_0000, 32'h7fc0_0000, 4'h8, "snan"});
    vecs.push_back('{32'h7fc0_0000, 32'h0000_0000, 32'h7fc0_0000, 4'h0, "qnan"});
    vecs.push_back('{32'h7f00_0000, 32'h4000_0000, 32'h7f80_0000, 4'h5, "overflow"});
    vecs.push_back('{32'h0080_0000, 32'h3f00_0000, 32'h0000_0000, 4'h3, "underflow"});
    vecs.push_back('{32'h8080_0000, 32'h3f00_0000, 32'h8000_0000, 4'h3, "underflow_neg"});

    // Pin the reference model to the hand-computed answers
    foreach (vecs[i]) chk({vecs[i].name, "_model"}, 64'(model_mul(vecs[i].x, vecs[i].y)),
                          64'({vecs[i].f, vecs[i].p}));

    @(negedge clk);
    chk("reset_product", 64'(prod_w[0]), 64'h0);
    chk("reset_flags", 64'(flags_w[0]), 64'h0);
    chk("reset_busy", 64'(busy_w), 64'h0);
    chk("reset_ready", 64'(ready_w), 64'h0);
    @(posedge clk);
    #1 clrn = 1'b1;

    foreach (vecs[i]) run_op(0, 1'b0, vecs[i].x, vecs[i].y, vecs[i].p, vecs[i].f, vecs[i].name);

    // Back-to-back: second start raised in the DONE cycle of the first
    run_op(0, 1'b0, 32'h4040_0000, 32'hbfc0_0000, 32'hc090_0000, 4'h0, "b2b_first");
    run_op(0, 1'b1, 32'h4000_0000, 32'h3f00_0000, 32'h3f80_0000, 4'h0, "b2b_second");

    // Start pulse while busy must be ignored
    @(posedge clk);
    #1;
    a_in       = 32'h4040_0000;
    b_in       = 32'hbfc0_0000;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    n = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      n++;
    end
    a_in       = 32'h4000_0000;
    b_in       = 32'h3f00_0000;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    n++;
    start_v[0] = 1'b0;
    while (!ready_w[0] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("busy_start_latency", 64'(n), 64'd27);
    chk("busy_start_product", 64'(prod_w[0]), 64'hc090_0000);

    // Asynchronous reset mid-operation
    @(posedge clk);
    #1;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1 clrn = 1'b0;
    @(negedge clk);
    chk("midreset_product", 64'(prod_w[0]), 64'h0);
    chk("midreset_busy", 64'(busy_w[0]), 64'h0);
    chk("midreset_ready", 64'(ready_w[0]), 64'h0);
    #1 clrn = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_w[0]) pulses++;
    end
    chk("no_ready_after_reset", 64'(pulses), 64'h0);
    run_op(0, 1'b0, 32'h4000_0000, 32'h3f00_0000, 32'h3f80_0000, 4'h0, "after_reset");

    run_op(1, 1'b0, 32'h4000_0000, 32'h3f00_0000, 32'h3f80_0000, 4'h0, "bpc2_basic");
    run_op(2, 1'b0, 32'h4000_0000, 32'h3f00_0000, 32'h3f80_0000, 4'h0, "bpc4_basic");
    run_op(2, 1'b0, 32'h3fc0_0000, 32'h3f80_0001, 32'h3fc0_0002, 4'h1, "bpc4_tie");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
